cam_capture_ctrl: RTL and testbench

Frame-capture sequencer and frame-buffer write-port arbiter for the OV-series camera path, clocked entirely in the CAM_pclk domain. It sits between the pixel-packing writer (12-bit RGB444 words, AW-bit addresses) and the dual-port frame buffer. It decides which frames are written (single snapshot or continuous), validates the pixel count per frame, and shares the buffer write port with an auxiliary writer (overlay/clear engine).

---
 rtl/cam_capture_ctrl_if.sv | 31 +++
 rtl/cam_capture_ctrl.sv | 120 ++++++++++++
 tb/tb_cam_capture_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_ctrl_if.sv
// Frame-buffer write-port bundle: camera pixel writer, auxiliary writer and
// the registered buffer port. slave = cam_capture_ctrl, master = the write sources and the frame buffer.
interface cam_capture_ctrl_if #(
   parameter int AW = 15,
   parameter int DW = 12
);
   logic          cam_we;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_data;
   logic          aux_req;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_data;
   logic          aux_gnt;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;

   modport slave (
      input  cam_we, cam_addr, cam_data,
      input  aux_req, aux_addr, aux_data,
      output aux_gnt,
      output mem_we, mem_addr, mem_data
   );

   modport master (
      output cam_we, cam_addr, cam_data,
      output aux_req, aux_addr, aux_data,
      input  aux_gnt,
      input  mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer and frame-buffer write-port arbiter (CAM_pclk domain).
// Define CAM_CTRL_AUX_EN to enable the auxiliary writer; otherwise aux_gnt is tied low.
module cam_capture_ctrl #(
   parameter int AW       = 15,
   parameter int DW       = 12,
   parameter int IMG_SIZE = 19200
) (
   input  logic               CAM_pclk,
   input  logic               rst,
   input  logic               CAM_vsync,
   input  logic               cmd_start,
   input  logic               cmd_cont,
   input  logic               cmd_abort,
   cam_capture_ctrl_if.slave  bus,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_err,
   output logic [AW:0]        pix_count
);

   localparam logic [AW:0] IMG_MAX = (AW+1)'(IMG_SIZE);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10
   } state_t;

   state_t      state, state_n;
   logic        vsync_q;
   logic        vs_fall, vs_rise;
   logic        in_cap, cam_fwd, cam_drop;
   logic        done_c, err_c, start_acc, arm_hit;
   logic        aux_sel;
   logic [AW:0] pix_inc;

   assign vs_fall = ~CAM_vsync &  vsync_q;
   assign vs_rise =  CAM_vsync & ~vsync_q;

   always_ff @(posedge CAM_pclk) begin
      if (rst) begin
         vsync_q <= 1'b0;
         state   <= IDLE;
      end else begin
         vsync_q <= CAM_vsync;
         state   <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (cmd_abort) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (cmd_start) state_n = ARMED;
            ARMED:   if (vs_fall)   state_n = CAPTURE;
            CAPTURE: if (vs_rise)   state_n = cmd_cont ? ARMED : IDLE;
            default:                state_n = IDLE;
         endcase
      end
   end

   // Abort wins over everything in its cycle: nothing is counted, flagged or completed.
   always_comb begin
      in_cap    = (state == CAPTURE) & ~cmd_abort;
      cam_fwd   = in_cap & bus.cam_we & (pix_count < IMG_MAX);
      cam_drop  = in_cap & bus.cam_we & ~(pix_count < IMG_MAX);
      pix_inc   = pix_count + {{AW{1'b0}}, cam_fwd};
      done_c    = in_cap & vs_rise & (pix_inc == IMG_MAX);
      err_c     = cam_drop | (in_cap & vs_rise & (pix_inc != IMG_MAX));
      start_acc = (state == IDLE) & cmd_start & ~cmd_abort;
      arm_hit   = (state == ARMED) & vs_fall & ~cmd_abort;
   end

`ifdef CAM_CTRL_AUX_EN
   always_comb bus.aux_gnt = ~rst & bus.aux_req & ~((state == CAPTURE) & bus.cam_we);
   assign aux_sel = bus.aux_gnt;
`else
   logic aux_unused;
   assign aux_unused = bus.aux_req;
   always_comb bus.aux_gnt = 1'b0;
   assign aux_sel = 1'b0;
`endif

   always_ff @(posedge CAM_pclk) begin
      if (rst) begin
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
      end else if (cam_fwd) begin
         bus.mem_we   <= 1'b1;
         bus.mem_addr <= bus.cam_addr;
         bus.mem_data <= bus.cam_data;
      end else if (aux_sel) begin
         bus.mem_we   <= 1'b1;
         bus.mem_addr <= bus.aux_addr;
         bus.mem_data <= bus.aux_data;
      end else begin
         bus.mem_we   <= 1'b0;
      end
   end

   always_ff @(posedge CAM_pclk) begin
      if (rst) begin
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         pix_count  <= '0;
      end else begin
         busy       <= (state_n != IDLE);
         frame_done <= done_c;
         if (start_acc)  frame_err <= 1'b0;
         else if (err_c) frame_err <= 1'b1;
         if (start_acc | arm_hit) pix_count <= '0;
         else if (cam_fwd)        pix_count <= pix_inc;
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with IMG_SIZE=16; aux expectations follow CAM_CTRL_AUX_EN.
module tb_cam_capture_ctrl;

`ifdef CAM_CTRL_AUX_EN
   localparam logic AUX = 1'b1;
`else
   localparam logic AUX = 1'b0;
`endif

   logic        CAM_pclk = 1'b0;
   logic        rst, CAM_vsync, cmd_start, cmd_cont, cmd_abort;
   logic        busy, frame_done, frame_err;
   logic [15:0] pix_count;
   int          total = 0;
   int          bad   = 0;

   cam_capture_ctrl_if #(.AW(15), .DW(12)) bus ();

   cam_capture_ctrl #(.AW(15), .DW(12), .IMG_SIZE(16)) dut (
      .CAM_pclk   (CAM_pclk),
      .rst        (rst),
      .CAM_vsync  (CAM_vsync),
      .cmd_start  (cmd_start),
      .cmd_cont   (cmd_cont),
      .cmd_abort  (cmd_abort),
      .bus        (bus.slave),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .pix_count  (pix_count)
   );

   always #5 CAM_pclk = ~CAM_pclk;

   task automatic step;
      @(posedge CAM_pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vs(input logic v);
      CAM_vsync = v;
      step;
   endtask

   task automatic pulse_start;
      cmd_start = 1'b1;
      step;
      cmd_start = 1'b0;
   endtask

   task automatic cam_wr(input logic [14:0] a, input logic [11:0] d, input logic exp_we);
      bus.cam_we   = 1'b1;
      bus.cam_addr = a;
      bus.cam_data = d;
      step;
      bus.cam_we   = 1'b0;
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(a));
         chk("mem_data", 32'(bus.mem_data), 32'(d));
      end
   endtask

   initial begin
      logic exp_g;
      rst = 1'b1; CAM_vsync = 1'b1; cmd_start = 1'b0; cmd_cont = 1'b0; cmd_abort = 1'b0;
      bus.cam_we = 1'b0; bus.cam_addr = '0; bus.cam_data = '0;
      bus.aux_req = 1'b1; bus.aux_addr = '0; bus.aux_data = '0;
      step; step;
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_data", 32'(bus.mem_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err", 32'(frame_err), 0);
      chk("rst_pix", 32'(pix_count), 0);
      chk("rst_aux_gnt", 32'(bus.aux_gnt), 0);
      bus.aux_req = 1'b0; rst = 1'b0;
      step;

      // nominal single frame
      pulse_start;
      chk("t1_busy", 32'(busy), 1);
      vs(1'b0);
      for (int i = 0; i < 16; i++) cam_wr(15'(256 + i), 12'(i * 7 + 1), 1'b1);
      step;
      chk("t1_we_off", 32'(bus.mem_we), 0);
      chk("t1_addr_hold", 32'(bus.mem_addr), 32'h10F);
      chk("t1_pix", 32'(pix_count), 16);
      vs(1'b1);
      chk("t1_done", 32'(frame_done), 1);
      chk("t1_busy_off", 32'(busy), 0);
      chk("t1_err", 32'(frame_err), 0);
      step;
      chk("t1_done_pulse", 32'(frame_done), 0);

      // short frame
      pulse_start; vs(1'b0);
      for (int i = 0; i < 12; i++) cam_wr(15'(i), 12'(i), 1'b1);
      vs(1'b1);
      chk("t2s_done", 32'(frame_done), 0);
      chk("t2s_err", 32'(frame_err), 1);
      chk("t2s_pix", 32'(pix_count), 12);

      // long frame: only 16 forwarded
      pulse_start;
      chk("t2l_err_clr", 32'(frame_err), 0);
      vs(1'b0);
      for (int i = 0; i < 20; i++) cam_wr(15'(32 + i), 12'(100 + i), i < 16);
      chk("t2l_err", 32'(frame_err), 1);
      chk("t2l_pix", 32'(pix_count), 16);
      vs(1'b1);
      chk("t2l_busy", 32'(busy), 0);

      // writes in IDLE, then start mid-frame
      bus.cam_we = 1'b1; step; step; bus.cam_we = 1'b0;
      chk("t3_idle_we", 32'(bus.mem_we), 0);
      chk("t3_idle_pix", 32'(pix_count), 16);
      vs(1'b0);
      pulse_start;
      chk("t3_busy", 32'(busy), 1);
      chk("t3_pix_clr", 32'(pix_count), 0);
      for (int i = 0; i < 3; i++) cam_wr(15'(i), 12'(i), 1'b0);
      chk("t3_armed_pix", 32'(pix_count), 0);
      vs(1'b1); vs(1'b0);
      for (int i = 0; i < 16; i++) cam_wr(15'(512 + i), 12'(i * 3), 1'b1);
      vs(1'b1);
      chk("t3_done", 32'(frame_done), 1);
      chk("t3_err", 32'(frame_err), 0);
      step;

      // continuous: three frames, drop cmd_cont during the third
      cmd_cont = 1'b1;
      pulse_start;
      for (int f = 0; f < 3; f++) begin
         vs(1'b0);
         for (int i = 0; i < 16; i++) begin
            if (f == 2 && i == 8) cmd_cont = 1'b0;
            cam_wr(15'(f * 64 + i), 12'(f * 16 + i), 1'b1);
         end
         vs(1'b1);
         chk("t4_done", 32'(frame_done), 1);
         chk("t4_busy", 32'(busy), 32'(f < 2));
         step;
         chk("t4_done_pulse", 32'(frame_done), 0);
      end

      // aux arbitration during capture
      pulse_start; vs(1'b0);
      bus.aux_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.cam_we   = (i % 2 == 0);
         bus.cam_addr = 15'(768 + i);
         bus.cam_data = 12'(i + 1);
         bus.aux_addr = 15'(1792 + i);
         bus.aux_data = 12'(2560 + i);
         exp_g = AUX & (i % 2 != 0);
         #1;
         chk("t5_gnt", 32'(bus.aux_gnt), 32'(exp_g));
         step;
         chk("t5_we", 32'(bus.mem_we), 32'((i % 2 == 0) | exp_g));
         if (i % 2 == 0) chk("t5_cam_addr", 32'(bus.mem_addr), 32'(768 + i));
         if (exp_g) begin
            chk("t5_aux_addr", 32'(bus.mem_addr), 32'(1792 + i));
            chk("t5_aux_data", 32'(bus.mem_data), 32'(2560 + i));
         end
      end
      bus.cam_we = 1'b0; bus.aux_req = 1'b0;
      chk("t5_pix", 32'(pix_count), 4);
      for (int i = 0; i < 12; i++) cam_wr(15'(900 + i), 12'(i), 1'b1);
      vs(1'b1);
      chk("t5_done", 32'(frame_done), 1);
      chk("t5_pix16", 32'(pix_count), 16);
      step;
      bus.aux_req = 1'b1; bus.cam_we = 1'b1;
      bus.aux_addr = 15'h555; bus.aux_data = 12'h3C3;
      #1;
      chk("t5_idle_gnt", 32'(bus.aux_gnt), 32'(AUX));
      step;
      bus.aux_req = 1'b0; bus.cam_we = 1'b0;
      chk("t5_idle_we", 32'(bus.mem_we), 32'(AUX));
`ifdef CAM_CTRL_AUX_EN
      chk("t5_idle_addr", 32'(bus.mem_addr), 32'h555);
`endif
      step;

      // abort mid-frame, then start+abort together
      pulse_start; vs(1'b0);
      for (int i = 0; i < 5; i++) cam_wr(15'(i), 12'(i), 1'b1);
      cmd_abort = 1'b1; step; cmd_abort = 1'b0;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_done", 32'(frame_done), 0);
      chk("t6_pix", 32'(pix_count), 5);
      chk("t6_err", 32'(frame_err), 0);
      vs(1'b1);
      chk("t6_no_done", 32'(frame_done), 0);
      chk("t6_pix_hold", 32'(pix_count), 5);
      cmd_start = 1'b1; cmd_abort = 1'b1; step;
      cmd_start = 1'b0; cmd_abort = 1'b0;
      chk("t6_sa_busy", 32'(busy), 0);
      vs(1'b0);
      cam_wr(15'h10, 12'h10, 1'b0);
      chk("t6_sa_pix", 32'(pix_count), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
